// File: rtl/router_pkg.sv
// ----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the 3-port packet scheduler.
//   dir_t          : 2-bit destination direction code carried with each packet
//   IDX_*          : bit position of each input/output in every 3-bit vector
//   dir_to_port_oh : destination code -> one-hot output port (0 for NONE)
//   inc3           : modulo-3 increment used for round-robin pointers
// ----------------------------------------------------------------------------
package router_pkg;

    typedef enum logic [1:0] {
        DIR_NONE  = 2'b00,
        DIR_X     = 2'b01,
        DIR_Y     = 2'b10,
        DIR_LOCAL = 2'b11
    } dir_t;

    localparam int IDX_X     = 2;
    localparam int IDX_Y     = 1;
    localparam int IDX_LOCAL = 0;
    localparam int NPORT     = 3;

    // One-hot output port selected by a destination code, in IDX_* bit order.
    function automatic logic [2:0] dir_to_port_oh(input logic [1:0] dir);
        logic [2:0] w_oh;
        case (dir)
            DIR_X:     w_oh = 3'b100;
            DIR_Y:     w_oh = 3'b010;
            DIR_LOCAL: w_oh = 3'b001;
            default:   w_oh = 3'b000;
        endcase
        return w_oh;
    endfunction

    // (v + 1) mod 3 for legal pointer values 0..2.
    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v >= 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// ----------------------------------------------------------------------------
// rr_arb3
// Combinational 3-way arbiter for one output port.
//   i_req     : requesting inputs (already masked by slot-free / enable)
//   i_aged    : inputs whose wait counter has saturated
//   i_rr      : round-robin start pointer (0..2)
//   o_gnt     : one-hot grant, zero when nothing requests
//   o_rr_next : pointer to use after this cycle (winner+1 mod 3, else hold)
// Aged requesters beat everything else, highest index first; otherwise the
// search starts at i_rr and walks upward modulo 3.
// ----------------------------------------------------------------------------
module rr_arb3
    import router_pkg::*;
(
    input  logic [2:0] i_req,
    input  logic [2:0] i_aged,
    input  logic [1:0] i_rr,
    output logic [2:0] o_gnt,
    output logic [1:0] o_rr_next
);

    logic [2:0] w_aged_req;
    logic [3:0] w_req4;     // padded so a stray pointer of 3 selects a zero
    logic [1:0] w_idx;
    logic [1:0] w_win;
    logic       w_found;

    always_comb begin
        w_aged_req = i_req & i_aged;
        w_req4     = {1'b0, i_req};
        w_idx      = i_rr;
        w_win      = 2'd0;
        w_found    = 1'b0;
        if (|w_aged_req) begin
            w_found = 1'b1;
            if (w_aged_req[2])      w_win = 2'd2;
            else if (w_aged_req[1]) w_win = 2'd1;
            else                    w_win = 2'd0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (!w_found && w_req4[w_idx]) begin
                    w_found = 1'b1;
                    w_win   = w_idx;
                end
                w_idx = inc3(w_idx);
            end
        end
        o_gnt     = w_found ? (3'b001 << w_win) : 3'b000;
        o_rr_next = w_found ? inc3(w_win) : i_rr;
    end

endmodule

// File: rtl/port_sched.sv
// ----------------------------------------------------------------------------
// port_sched
// Three-input / three-output packet scheduler (X, Y, LOCAL). Each input owns a
// one-entry hold register; each output owns a one-entry output register fed
// by a per-port rr_arb3.
//
// Ports (every 3-bit vector: bit 2 = X, bit 1 = Y, bit 0 = LOCAL)
//   clk, rst_n            : clock, asynchronous active-low reset
//   enable                : run (1) / freeze (0)
//   in_valid, in_ready    : per-input handshake
//   in_dst_*, in_data_*   : per-input destination code and payload
//   out_valid, out_ready  : per-output handshake
//   out_data_*, out_src_* : per-output payload and source input index
//   fail                  : registered "held but not granted" per input
//
// Handshake: a transfer happens at a rising edge where valid and ready are
// both high. in_ready depends only on state, enable and this cycle's grants,
// never on in_valid. An output holds valid/data/src stable until out_ready is
// seen at an edge; a grant at that same edge replaces the content directly.
// ----------------------------------------------------------------------------
module port_sched
    import router_pkg::*;
#(
    parameter int DW      = 8,
    parameter int AGE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [2:0]    in_valid,
    input  logic [1:0]    in_dst_x,
    input  logic [1:0]    in_dst_y,
    input  logic [1:0]    in_dst_local,
    input  logic [DW-1:0] in_data_x,
    input  logic [DW-1:0] in_data_y,
    input  logic [DW-1:0] in_data_local,
    output logic [2:0]    in_ready,
    output logic [2:0]    out_valid,
    output logic [DW-1:0] out_data_x,
    output logic [DW-1:0] out_data_y,
    output logic [DW-1:0] out_data_local,
    output logic [1:0]    out_src_x,
    output logic [1:0]    out_src_y,
    output logic [1:0]    out_src_local,
    input  logic [2:0]    out_ready,
    output logic [2:0]    fail
);

    localparam logic [2:0] AGE_SAT = 3'(AGE_MAX);

    // Inputs gathered into arrays indexed by IDX_*.
    logic [1:0]    w_in_dst  [NPORT];
    logic [DW-1:0] w_in_data [NPORT];

    assign w_in_dst[IDX_X]      = in_dst_x;
    assign w_in_dst[IDX_Y]      = in_dst_y;
    assign w_in_dst[IDX_LOCAL]  = in_dst_local;
    assign w_in_data[IDX_X]     = in_data_x;
    assign w_in_data[IDX_Y]     = in_data_y;
    assign w_in_data[IDX_LOCAL] = in_data_local;

    // State
    logic [2:0]    r_hold_v;
    logic [1:0]    r_dst      [NPORT];
    logic [DW-1:0] r_data     [NPORT];
    logic [2:0]    r_age      [NPORT];
    logic [1:0]    r_rr       [NPORT];
    logic [2:0]    r_out_valid;
    logic [DW-1:0] r_out_data [NPORT];
    logic [1:0]    r_out_src  [NPORT];
    logic [2:0]    r_fail;

    // Arbitration wiring
    logic [2:0] w_map      [NPORT];   // per input: one-hot target port
    logic [2:0] w_req_port [NPORT];   // per port: which inputs target it
    logic [2:0] w_arb_req  [NPORT];
    logic [2:0] w_gnt_port [NPORT];
    logic [1:0] w_rr_next  [NPORT];
    logic [1:0] w_win_idx  [NPORT];
    logic [2:0] w_slot_free;
    logic [2:0] w_aged;
    logic [2:0] w_grant_in;
    logic [2:0] w_accept;

    for (genvar i = 0; i < NPORT; i++) begin : g_in
        assign w_map[i]      = dir_to_port_oh(r_dst[i]);
        assign w_aged[i]     = (r_age[i] == AGE_SAT);
        // An input targets exactly one port, so at most one term is set.
        assign w_grant_in[i] = w_gnt_port[0][i] | w_gnt_port[1][i] | w_gnt_port[2][i];
    end

    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            w_req_port[p] = 3'b000;
            for (int i = 0; i < NPORT; i++) begin
                w_req_port[p][i] = r_hold_v[i] & w_map[i][p];
            end
        end
    end

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        assign w_slot_free[p] = ~r_out_valid[p] | out_ready[p];
        assign w_arb_req[p]   = w_req_port[p] & {3{enable & w_slot_free[p]}};

        rr_arb3 u_arb (
            .i_req     (w_arb_req[p]),
            .i_aged    (w_aged),
            .i_rr      (r_rr[p]),
            .o_gnt     (w_gnt_port[p]),
            .o_rr_next (w_rr_next[p])
        );

        assign w_win_idx[p] = w_gnt_port[p][2] ? 2'd2 :
                              (w_gnt_port[p][1] ? 2'd1 : 2'd0);
    end

    // A granted input frees its hold at this edge, so it may accept again.
    assign in_ready = {3{enable}} & (~r_hold_v | w_grant_in);
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_v    <= 3'b000;
            r_out_valid <= 3'b000;
            r_fail      <= 3'b000;
            for (int i = 0; i < NPORT; i++) begin
                r_dst[i]      <= DIR_NONE;
                r_data[i]     <= '0;
                r_age[i]      <= 3'd0;
                r_rr[i]       <= 2'd0;
                r_out_data[i] <= '0;
                r_out_src[i]  <= 2'd0;
            end
        end else begin
            r_fail <= {3{enable}} & r_hold_v & ~w_grant_in;
            if (enable) begin
                for (int p = 0; p < NPORT; p++) begin
                    if (|w_gnt_port[p]) begin
                        r_out_valid[p] <= 1'b1;
                        r_out_data[p]  <= r_data[w_win_idx[p]];
                        r_out_src[p]   <= w_win_idx[p];
                    end else if (out_ready[p]) begin
                        r_out_valid[p] <= 1'b0;
                    end
                    r_rr[p] <= w_rr_next[p];
                end
                for (int i = 0; i < NPORT; i++) begin
                    // A packet with no destination is accepted and dropped.
                    if (w_accept[i]) begin
                        r_hold_v[i] <= (w_in_dst[i] != DIR_NONE);
                        r_dst[i]    <= w_in_dst[i];
                        r_data[i]   <= w_in_data[i];
                    end else if (w_grant_in[i]) begin
                        r_hold_v[i] <= 1'b0;
                    end
                    if (r_hold_v[i] && !w_grant_in[i]) begin
                        if (r_age[i] != AGE_SAT) r_age[i] <= r_age[i] + 3'd1;
                    end else begin
                        r_age[i] <= 3'd0;
                    end
                end
            end
        end
    end

    assign out_valid      = r_out_valid;
    assign out_data_x     = r_out_data[IDX_X];
    assign out_data_y     = r_out_data[IDX_Y];
    assign out_data_local = r_out_data[IDX_LOCAL];
    assign out_src_x      = r_out_src[IDX_X];
    assign out_src_y      = r_out_src[IDX_Y];
    assign out_src_local  = r_out_src[IDX_LOCAL];
    assign fail           = r_fail;

endmodule

// File: tb/tb_port_sched.sv
// ----------------------------------------------------------------------------
// tb_port_sched
// Directed scenarios with literal expectations plus a long randomized run.
// A cycle-level behavioural model (queues of held packets and per-port
// arbitration written straight from the scheduling rules) runs alongside the
// DUT; a negedge compare process checks every output each cycle.
// ----------------------------------------------------------------------------
module tb_port_sched;

  localparam int DW      = 8;
  localparam int AGE_MAX = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          enable = 1'b0;
  logic [2:0]    in_valid = 3'b000;
  logic [1:0]    t_dst [3];
  logic [DW-1:0] t_data [3];
  logic [2:0]    out_ready = 3'b000;

  logic [2:0]    in_ready, out_valid, fail;
  logic [DW-1:0] out_data_x, out_data_y, out_data_local;
  logic [1:0]    out_src_x, out_src_y, out_src_local;
  logic [DW-1:0] o_data [3];
  logic [1:0]    o_src [3];

  assign o_data[2] = out_data_x;
  assign o_data[1] = out_data_y;
  assign o_data[0] = out_data_local;
  assign o_src[2]  = out_src_x;
  assign o_src[1]  = out_src_y;
  assign o_src[0]  = out_src_local;

  port_sched #(.DW(DW), .AGE_MAX(AGE_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
    .in_dst_x(t_dst[2]), .in_dst_y(t_dst[1]), .in_dst_local(t_dst[0]),
    .in_data_x(t_data[2]), .in_data_y(t_data[1]), .in_data_local(t_data[0]),
    .in_ready(in_ready), .out_valid(out_valid),
    .out_data_x(out_data_x), .out_data_y(out_data_y), .out_data_local(out_data_local),
    .out_src_x(out_src_x), .out_src_y(out_src_y), .out_src_local(out_src_local),
    .out_ready(out_ready), .fail(fail)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic          m_hold_v [3];
  logic [1:0]    m_dst [3];
  logic [DW-1:0] m_data [3];
  int            m_age [3];
  int            m_rr [3];
  logic          m_ov [3];
  logic [DW-1:0] m_od [3];
  int            m_os [3];
  logic          m_fail [3];
  int            a_win [3];   // winning input per port this cycle, -1 if none

  // destination code -> output port number
  function automatic int port_of(input logic [1:0] d);
    case (d)
      2'b01:   return 2;
      2'b10:   return 1;
      2'b11:   return 0;
      default: return -1;
    endcase
  endfunction

  function automatic bit wants(input int i, input int p);
    return m_hold_v[i] && (port_of(m_dst[i]) == p);
  endfunction

  task automatic m_arbitrate();
    for (int p = 0; p < 3; p++) begin
      a_win[p] = -1;
      if (enable && (!m_ov[p] || out_ready[p])) begin
        for (int i = 2; i >= 0; i--)
          if (a_win[p] < 0 && wants(i, p) && m_age[i] == AGE_MAX) a_win[p] = i;
        for (int k = 0; k < 3; k++) begin
          int i;
          i = (m_rr[p] + k) % 3;
          if (a_win[p] < 0 && wants(i, p)) a_win[p] = i;
        end
      end
    end
  endtask

  function automatic bit m_granted(input int i);
    return (a_win[0] == i) || (a_win[1] == i) || (a_win[2] == i);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      m_hold_v[i] = 1'b0; m_dst[i] = 2'b00; m_data[i] = '0; m_age[i] = 0;
      m_rr[i] = 0; m_ov[i] = 1'b0; m_od[i] = '0; m_os[i] = 0; m_fail[i] = 1'b0;
    end
  endtask

  task automatic m_step();
    bit g [3];
    bit rdy;
    m_arbitrate();
    if (!enable) begin
      for (int i = 0; i < 3; i++) m_fail[i] = 1'b0;
      return;
    end
    for (int i = 0; i < 3; i++) g[i] = m_granted(i);
    for (int p = 0; p < 3; p++) begin
      if (a_win[p] >= 0) begin
        m_ov[p] = 1'b1;
        m_od[p] = m_data[a_win[p]];
        m_os[p] = a_win[p];
        m_rr[p] = (a_win[p] + 1) % 3;
      end else if (out_ready[p]) begin
        m_ov[p] = 1'b0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      rdy = !m_hold_v[i] || g[i];
      m_fail[i] = m_hold_v[i] && !g[i];
      if (m_hold_v[i] && !g[i]) m_age[i] = (m_age[i] < AGE_MAX) ? m_age[i] + 1 : AGE_MAX;
      else m_age[i] = 0;
      if (in_valid[i] && rdy) begin
        m_hold_v[i] = (t_dst[i] != 2'b00);
        m_dst[i] = t_dst[i];
        m_data[i] = t_data[i];
      end else if (g[i]) begin
        m_hold_v[i] = 1'b0;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  // ---------------- per-cycle compare process ----------------
  initial begin
    logic [2:0] e_rdy;
    forever begin
      @(negedge clk);
      if (rst_n && chk_on) begin
        m_arbitrate();
        for (int i = 0; i < 3; i++) e_rdy[i] = enable && (!m_hold_v[i] || m_granted(i));
        chk("in_ready", 32'(in_ready), 32'(e_rdy));
        chk("out_valid", 32'(out_valid), 32'({m_ov[2], m_ov[1], m_ov[0]}));
        chk("fail", 32'(fail), 32'({m_fail[2], m_fail[1], m_fail[0]}));
        for (int p = 0; p < 3; p++) begin
          chk($sformatf("out_data[%0d]", p), 32'(o_data[p]), 32'(m_od[p]));
          chk($sformatf("out_src[%0d]", p), 32'(o_src[p]), 32'(m_os[p]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic to_drive();   // step to the drive point of the next cycle
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic [2:0] v, input logic [1:0] dx, input logic [1:0] dy,
                        input logic [1:0] dl, input logic [DW-1:0] ax,
                        input logic [DW-1:0] ay, input logic [DW-1:0] al);
    in_valid = v;
    t_dst[2] = dx; t_dst[1] = dy; t_dst[0] = dl;
    t_data[2] = ax; t_data[1] = ay; t_data[0] = al;
  endtask

  task automatic rand_in();
    in_valid = 3'($urandom_range(0, 7));
    for (int i = 0; i < 3; i++) begin
      t_dst[i]  = 2'($urandom_range(0, 3));
      t_data[i] = DW'($urandom);
      out_ready[i] = ($urandom_range(0, 3) != 0);
    end
  endtask

  // Asynchronous reset asserted between edges, checked immediately.
  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst fail", 32'(fail), 32'd0);
    chk("rst out_data", 32'({out_data_x, out_data_y, out_data_local}), 32'd0);
    chk("rst out_src", 32'({out_src_x, out_src_y, out_src_local}), 32'd0);
    to_drive();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  int cnt [3];

  initial begin
    set_in(3'b000, 2'b00, 2'b00, 2'b00, '0, '0, '0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    enable = 1'b1;
    out_ready = 3'b111;
    chk_on = 1'b1;

    // reset state
    @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset fail", 32'(fail), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'b111);

    // X and Y to port X with rr_x = 0: search 0,1,2 finds Y first
    to_drive(); set_in(3'b110, 2'b01, 2'b01, 2'b00, 8'hA2, 8'hA1, 8'h00);
    to_drive(); in_valid = 3'b000;
    @(negedge clk); chk("c1 in_ready", 32'(in_ready), 32'b011);
    @(negedge clk); chk("c1 src first", 32'(out_src_x), 32'd1);
    chk("c1 data first", 32'(out_data_x), 32'hA1);
    chk("c1 fail", 32'(fail), 32'b100);
    @(negedge clk); chk("c1 src second", 32'(out_src_x), 32'd2);
    chk("c1 data second", 32'(out_data_x), 32'hA2);
    chk("c1 fail clear", 32'(fail), 32'b000);
    @(negedge clk); chk("c1 drained", 32'(out_valid), 32'b000);

    // Prime rr_x to 2 with a single Y packet, then X and Y together: 2 then 1
    to_drive(); set_in(3'b010, 2'b00, 2'b01, 2'b00, 8'h00, 8'hB1, 8'h00);
    to_drive(); in_valid = 3'b000;
    to_drive(); set_in(3'b110, 2'b01, 2'b01, 2'b00, 8'hC2, 8'hC1, 8'h00);
    to_drive(); in_valid = 3'b000;
    @(negedge clk); chk("c2 in_ready", 32'(in_ready), 32'b101);
    @(negedge clk); chk("c2 src first", 32'(out_src_x), 32'd2);
    chk("c2 fail", 32'(fail), 32'b010);
    @(negedge clk); chk("c2 src second", 32'(out_src_x), 32'd1);
    chk("c2 data second", 32'(out_data_x), 32'hC1);
    chk("c2 fail clear", 32'(fail), 32'b000);

    // dst NONE: accepted and dropped
    to_drive(); in_valid = 3'b000;
    to_drive(); set_in(3'b001, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h5A);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("none in_ready", 32'(in_ready[0]), 32'd1);
      chk("none out_valid", 32'(out_valid), 32'd0);
      chk("none fail", 32'(fail), 32'd0);
      to_drive();
    end

    // All three stream to LOCAL: fair rotation
    set_in(3'b111, 2'b11, 2'b11, 2'b11, 8'h01, 8'h02, 8'h03);
    out_ready = 3'b111;
    for (int i = 0; i < 3; i++) cnt[i] = 0;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < 3; i++) t_data[i] = DW'($urandom);
      @(negedge clk);
      if (c >= 3) begin
        chk("rot valid", 32'(out_valid[0]), 32'd1);
        if (out_valid[0]) cnt[out_src_local]++;
      end
      to_drive();
    end
    for (int i = 0; i < 3; i++) chk($sformatf("rot count src%0d", i), 32'(cnt[i]), 32'd3);
    in_valid = 3'b000;

    // Blocked port X: LOCAL wins first (rr=0), X and Y age out, X then Y
    do_reset();
    set_in(3'b111, 2'b01, 2'b01, 2'b01, 8'hD2, 8'hD1, 8'hD0);
    out_ready = 3'b000;
    to_drive(); in_valid = 3'b000;
    @(negedge clk); chk("age in_ready", 32'(in_ready), 32'b001);
    to_drive();
    @(negedge clk);
    chk("age hold valid", 32'(out_valid[2]), 32'd1);
    chk("age hold src", 32'(out_src_x), 32'd0);
    chk("age fail", 32'(fail), 32'b110);
    for (int c = 0; c < 4; c++) begin
      to_drive();
      if (c == 3) out_ready = 3'b100;
      @(negedge clk);
      chk("age hold valid", 32'(out_valid[2]), 32'd1);
      chk("age hold src", 32'(out_src_x), 32'd0);
      chk("age hold data", 32'(out_data_x), 32'hD0);
    end
    @(negedge clk); chk("aged winner src", 32'(out_src_x), 32'd2);
    chk("aged winner data", 32'(out_data_x), 32'hD2);
    @(negedge clk); chk("aged next src", 32'(out_src_x), 32'd1);
    chk("aged next data", 32'(out_data_x), 32'hD1);

    // Stream, freeze for 3 cycles, then asynchronous reset while frozen
    for (int c = 0; c < 12; c++) begin to_drive(); rand_in(); end
    to_drive(); enable = 1'b0; rand_in();
    @(negedge clk); chk("frz in_ready", 32'(in_ready), 32'd0);
    for (int c = 0; c < 2; c++) begin
      to_drive(); rand_in();
      @(negedge clk);
      chk("frz in_ready", 32'(in_ready), 32'd0);
      chk("frz fail", 32'(fail), 32'd0);
    end
    do_reset();
    enable = 1'b1;
    in_valid = 3'b000;

    // Randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      to_drive();
      rand_in();
      enable = ($urandom_range(0, 9) != 0);
    end

    to_drive();
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
